// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. It decodes memory-wait,
// redirect and load-use hazards in strict priority order and drives the per-stage
// stall/flush strobes combinationally. It also keeps saturating stall/flush
// performance counters and a sticky data-memory timeout flag.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_stall,
    output logic             id_flush,
    output logic             ex_mem_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err,
    output logic [1:0]       ctrl_state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              err_q, err_d;

    logic memwait, redirect, loaduse;
    logic pc_stall_raw, if_id_stall_raw, if_id_flush_raw;
    logic id_stall_raw, id_flush_raw, ex_mem_stall_raw;

    // Hazard event decode from the current stage contents; x0 never creates a dependency.
    always_comb begin
        memwait  = mem_req & ~mem_ready;
        redirect = ex_redirect;
        loaduse  = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    end

    // Priority-resolved strobes: memory wait freezes everything, redirect squashes, load-use bubbles.
    always_comb begin
        pc_stall_raw     = 1'b0;
        if_id_stall_raw  = 1'b0;
        if_id_flush_raw  = 1'b0;
        id_stall_raw     = 1'b0;
        id_flush_raw     = 1'b0;
        ex_mem_stall_raw = 1'b0;
        if (memwait) begin
            pc_stall_raw     = 1'b1;
            if_id_stall_raw  = 1'b1;
            id_stall_raw     = 1'b1;
            ex_mem_stall_raw = 1'b1;
        end else if (redirect) begin
            if_id_flush_raw  = 1'b1;
            id_flush_raw     = 1'b1;
        end else if (loaduse) begin
            pc_stall_raw     = 1'b1;
            if_id_stall_raw  = 1'b1;
            id_flush_raw     = 1'b1;
        end
    end

    // Strobes are forced low while reset is held so stage registers see no spurious stall/flush.
    always_comb begin
        pc_stall     = pc_stall_raw     & rst_n;
        if_id_stall  = if_id_stall_raw  & rst_n;
        if_id_flush  = if_id_flush_raw  & rst_n;
        id_stall     = id_stall_raw     & rst_n;
        id_flush     = id_flush_raw     & rst_n;
        ex_mem_stall = ex_mem_stall_raw & rst_n;
    end

    // Next-state logic for the debug FSM, the wait-run counter, the timeout flag and perf counters.
    // The wait counter measures the current run of consecutive memwait cycles, entry cycle included.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        err_d       = err_q;

        case (state_q)
            ST_RUN: begin
                if (memwait)                   state_d = ST_MEM_WAIT;
                else if (loaduse && !redirect) state_d = ST_LOAD_STALL;
                else                           state_d = ST_RUN;
            end
            ST_LOAD_STALL: begin
                if (memwait) state_d = ST_MEM_WAIT;
                else         state_d = ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (memwait) state_d = ST_MEM_WAIT;
                else         state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        if (!memwait) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end

        if (wait_cnt_d == WAIT_MAX) begin
            err_d = 1'b1;
        end

        if (pc_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (if_id_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // State registers; asynchronous reset returns to RUN and clears every counter and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    // Registered status outputs.
    always_comb begin
        stall_cnt       = stall_cnt_q;
        flush_cnt       = flush_cnt_q;
        mem_timeout_err = err_q;
        ctrl_state      = state_q;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Table-driven strobe vectors, hand-written multi-cycle sequences, and a randomized run
// checked against a behavioural model of the hazard controller.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
    logic             mem_req, mem_ready;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             pc_stall, if_id_stall, if_id_flush, id_stall, id_flush, ex_mem_stall;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout_err;
    logic [1:0]       ctrl_state;
    logic [5:0]       out_vec;

    int checks = 0;
    int passes = 0;

    // Stimulus record with expected strobes {pc, if_id_stall, if_id_flush, id_stall, id_flush, ex_mem_stall}.
    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       redir;
        logic       req;
        logic       rdy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[13];
    vec_t idle;

    // Behavioural model state.
    int m_state, m_stall, m_flush, m_run;
    bit m_err;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_stall(id_stall), .id_flush(id_flush), .ex_mem_stall(ex_mem_stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_timeout_err(mem_timeout_err), .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    assign out_vec = {pc_stall, if_id_stall, if_id_flush, id_stall, id_flush, ex_mem_stall};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input vec_t s);
        id_valid = s.v; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
        ex_mem_read = s.mr; ex_rd = s.rd; ex_redirect = s.redir;
        mem_req = s.req; mem_ready = s.rdy;
    endtask

    // Moves to just after the next rising edge, applies the inputs, then settles.
    task automatic applyStimulus(input vec_t s);
        @(posedge clk);
        #1;
        drive(s);
        #1;
    endtask

    task automatic doReset();
        drive(idle);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_state = 0; m_stall = 0; m_flush = 0; m_run = 0; m_err = 0;
    endtask

    function automatic vec_t mk(input logic v, input int rs1, input int rs2, input logic u1,
                                input logic u2, input logic mr, input int rd, input logic redir,
                                input logic req, input logic rdy, input logic [5:0] exp);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = u1; r.u2 = u2; r.mr = mr;
        r.rd = 5'(rd); r.redir = redir; r.req = req; r.rdy = rdy; r.exp = exp;
        return r;
    endfunction

    // Reference strobes straight from the hazard priority rules.
    function automatic logic [5:0] modelOut(input vec_t s);
        bit mw, rd_hit, lu;
        mw     = s.req && !s.rdy;
        rd_hit = (s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd);
        lu     = s.v && s.mr && s.rd != 0 && rd_hit;
        if (mw)           return 6'b110101;
        else if (s.redir) return 6'b001010;
        else if (lu)      return 6'b110010;
        else              return 6'b000000;
    endfunction

    // Advance the model across one rising edge given the inputs held during the cycle.
    task automatic modelStep(input vec_t s);
        logic [5:0] o;
        bit mw, lu;
        int cmax;
        cmax = (1 << CNT_W) - 1;
        o  = modelOut(s);
        mw = s.req && !s.rdy;
        lu = (o == 6'b110010);
        if (o[5] && m_stall < cmax) m_stall++;
        if (o[3] && m_flush < cmax) m_flush++;
        m_run = mw ? m_run + 1 : 0;
        if (m_run >= MEM_TIMEOUT) m_err = 1;
        if (mw)                       m_state = 2;
        else if (m_state == 0 && lu)  m_state = 1;
        else                          m_state = 0;
    endtask

    initial begin
        vec_t s;
        vec_t lu_vec;

        idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
        lu_vec = mk(1, 5, 1, 1, 1, 1, 5, 0, 0, 0, 6'b110010);

        vecs[0]  = idle;
        vecs[1]  = lu_vec;
        vecs[2]  = mk(1, 7, 9, 0, 1, 1, 9, 0, 0, 0, 6'b110010);
        vecs[3]  = mk(1, 9, 3, 0, 1, 1, 9, 0, 0, 0, 6'b000000);
        vecs[4]  = mk(0, 5, 5, 1, 1, 1, 5, 0, 0, 0, 6'b000000);
        vecs[5]  = mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 6'b000000);
        vecs[6]  = mk(1, 5, 5, 1, 1, 0, 5, 0, 0, 0, 6'b000000);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001010);
        vecs[8]  = mk(1, 5, 1, 1, 1, 1, 5, 1, 0, 0, 6'b001010);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b110101);
        vecs[10] = mk(1, 5, 1, 1, 1, 1, 5, 1, 1, 0, 6'b110101);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6'b001010);
        vecs[12] = mk(1, 5, 1, 1, 1, 1, 5, 0, 0, 1, 6'b110010);

        // Reset state, including strobes held low while reset is asserted.
        drive(vecs[9]);
        #2;
        checkOutput("reset_strobes_gated", 32'(out_vec), 32'h0);
        doReset();
        checkOutput("reset_state", 32'(ctrl_state), 32'd0);
        checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        checkOutput("reset_err", 32'(mem_timeout_err), 32'd0);

        // Table of single-cycle strobe vectors.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_strobes", i), 32'(out_vec), 32'(vecs[i].exp));
        end

        // Load-use: one-cycle stall then back to RUN.
        doReset();
        applyStimulus(lu_vec);
        checkOutput("lu_strobes", 32'(out_vec), 32'b110010);
        applyStimulus(idle);
        checkOutput("lu_state_stall", 32'(ctrl_state), 32'd1);
        checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        checkOutput("lu_after_strobes", 32'(out_vec), 32'd0);
        applyStimulus(idle);
        checkOutput("lu_state_run", 32'(ctrl_state), 32'd0);

        // Load to x0 never stalls.
        applyStimulus(vecs[5]);
        checkOutput("x0_strobes", 32'(out_vec), 32'd0);
        applyStimulus(idle);
        checkOutput("x0_state", 32'(ctrl_state), 32'd0);

        // Redirect wins over load-use.
        doReset();
        applyStimulus(vecs[8]);
        checkOutput("redir_strobes", 32'(out_vec), 32'b001010);
        applyStimulus(idle);
        checkOutput("redir_flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("redir_state", 32'(ctrl_state), 32'd0);
        checkOutput("redir_stall_cnt", 32'(stall_cnt), 32'd0);

        // Memory wait masks a redirect for 3 cycles; flush lands in the ready cycle.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(vecs[10]);
            checkOutput($sformatf("mw_strobes_c%0d", k), 32'(out_vec), 32'b110101);
            if (k > 0) checkOutput($sformatf("mw_state_c%0d", k), 32'(ctrl_state), 32'd2);
        end
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6'b001010));
        checkOutput("mw_release_strobes", 32'(out_vec), 32'b001010);
        checkOutput("mw_release_stall_cnt", 32'(stall_cnt), 32'd3);
        applyStimulus(idle);
        checkOutput("mw_release_state", 32'(ctrl_state), 32'd0);
        checkOutput("mw_release_flush_cnt", 32'(flush_cnt), 32'd1);

        // Timeout: set from the 5th wait cycle, sticky until reset.
        doReset();
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(vecs[9]);
            checkOutput($sformatf("to_err_c%0d", k), 32'(mem_timeout_err), (k >= 5) ? 32'd1 : 32'd0);
        end
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b000000));
        applyStimulus(idle);
        checkOutput("to_err_sticky", 32'(mem_timeout_err), 32'd1);
        checkOutput("to_stall_sat", 32'(stall_cnt), 32'd6);

        // Asynchronous reset in the middle of a memory wait.
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(vecs[9]);
        checkOutput("async_pre_state", 32'(ctrl_state), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_strobes", 32'(out_vec), 32'd0);
        checkOutput("async_state", 32'(ctrl_state), 32'd0);
        checkOutput("async_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("async_err", 32'(mem_timeout_err), 32'd0);

        // Randomized run against the behavioural model.
        doReset();
        for (int n = 0; n < 400; n++) begin
            s.v     = 1'($urandom_range(0, 3) != 0);
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.u1    = 1'($urandom_range(0, 1));
            s.u2    = 1'($urandom_range(0, 1));
            s.mr    = 1'($urandom_range(0, 1));
            s.rd    = 5'($urandom_range(0, 3));
            s.redir = 1'($urandom_range(0, 5) == 0);
            s.req   = 1'($urandom_range(0, 2) == 0);
            s.rdy   = 1'($urandom_range(0, 2) == 0);
            s.exp   = 6'b0;
            applyStimulus(s);
            checkOutput("rnd_strobes", 32'(out_vec), 32'(modelOut(s)));
            checkOutput("rnd_state", 32'(ctrl_state), 32'(m_state));
            checkOutput("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));
            checkOutput("rnd_flush_cnt", 32'(flush_cnt), 32'(m_flush));
            checkOutput("rnd_err", 32'(mem_timeout_err), 32'(m_err));
            modelStep(s);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
